psk_symbol_mapper: RTL and testbench

- Serial-bit to phase-select stage directly upstream of the 3-bit phase-select multiplexer.
- Packs an incoming serial bitstream into symbols of BITS_PER_SYM bits and Gray-maps each symbol to a 3-bit phase code (0..7 = 0°..315° in 45° steps).
- Buffers one output symbol behind a valid/ready handshake, so the modulator back-end can stall the bit source.

---
 rtl/psk_symbol_mapper.sv | 154 +++++++++++++++
 tb/tb_psk_symbol_mapper.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper
//   Packs a serial bitstream into BITS_PER_SYM-bit symbols (first bit = MSB)
//   and Gray-maps each symbol onto a 3-bit phase code (0..7 = 0..315 deg in
//   45 deg steps) for the downstream phase-select multiplexer. One output
//   symbol is buffered behind a valid/ready handshake.
//
// Parameters
//   BITS_PER_SYM  2 = QPSK (odd phases only), 3 = 8-PSK; any other value
//                 stops elaboration.
//
// Ports
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset
//   bit_in     serial data bit
//   bit_valid  bit_in is valid this cycle
//   bit_ready  block accepts bit_in this cycle (combinational from sym_ready)
//   flush      zero-pad the current partial symbol and emit it
//   phase_sel  phase code for the multiplexer select
//   sym_valid  phase_sel holds an unconsumed symbol
//   sym_ready  downstream consumes phase_sel this cycle
//
// Optional feature
//   PSK_DIFF_ENC_EN  when defined, phase_sel is the running mod-8 sum of the
//                    mapped codes (differential encoding), updated on loads.
module psk_symbol_mapper #(
  parameter int unsigned BITS_PER_SYM = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       flush,
  output logic [2:0] phase_sel,
  output logic       sym_valid,
  input  logic       sym_ready
);

  generate
    if (BITS_PER_SYM != 2 && BITS_PER_SYM != 3) begin : g_bad_param
      $error("psk_symbol_mapper: BITS_PER_SYM must be 2 or 3");
    end
  endgenerate

  localparam int unsigned   CW    = $clog2(BITS_PER_SYM);
  localparam logic [CW-1:0] LAST  = CW'(BITS_PER_SYM - 1);
  localparam logic [CW:0]   SYM_W = (CW + 1)'(BITS_PER_SYM);

  // ST_FLUSH_WAIT: a flush arrived while the output register was full and
  // not draining; the partial symbol waits here with bit intake blocked.
  typedef enum logic {
    ST_RUN,
    ST_FLUSH_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] sh_q, sh_d;
  logic [2:0]              phase_q, phase_d;
  logic                    valid_q, valid_d;

  logic                    space;
  logic                    accept;
  logic                    complete;
  logic                    want_flush;
  logic                    load;
  logic [CW-1:0]           cnt_acc;
  logic [BITS_PER_SYM-1:0] sh_acc;
  logic [BITS_PER_SYM-1:0] sym;
  logic [CW:0]             shamt;
  logic [2:0]              code;
  logic [2:0]              phase_load;

  assign space     = !valid_q || sym_ready;
  assign bit_ready = (state_q == ST_RUN) && ((cnt_q != LAST) || space);
  assign accept    = bit_valid && bit_ready;
  assign complete  = accept && (cnt_q == LAST);

  // Bit-intake view of the packer, including a bit accepted this cycle.
  always_comb begin
    sh_acc  = sh_q;
    cnt_acc = cnt_q;
    if (accept) begin
      sh_acc  = {sh_q[BITS_PER_SYM-2:0], bit_in};
      cnt_acc = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // A completed symbol already wrapped cnt_acc to 0, so a flush in the same
  // cycle never produces a second (padded) symbol.
  assign want_flush = (flush || state_q == ST_FLUSH_WAIT) && (cnt_acc != '0);
  assign load       = complete || (want_flush && space);
  assign shamt      = SYM_W - {1'b0, cnt_acc};
  assign sym        = complete ? sh_acc : (sh_acc << shamt);

  generate
    if (BITS_PER_SYM == 2) begin : g_qpsk
      always_comb begin
        case (sym)
          2'b00:   code = 3'b001;
          2'b01:   code = 3'b011;
          2'b11:   code = 3'b101;
          default: code = 3'b111;
        endcase
      end
    end else begin : g_8psk
      // Gray-to-binary conversion of the 3 symbol bits.
      always_comb begin
        code = {sym[2], sym[2] ^ sym[1], sym[2] ^ sym[1] ^ sym[0]};
      end
    end
  endgenerate

`ifdef PSK_DIFF_ENC_EN
  // phase_q only changes on loads and resets to 0, so it is the accumulator.
  assign phase_load = phase_q + code;
`else
  assign phase_load = code;
`endif

  always_comb begin
    state_d = (want_flush && !space) ? ST_FLUSH_WAIT : ST_RUN;
    cnt_d   = cnt_acc;
    sh_d    = sh_acc;
    phase_d = phase_q;
    valid_d = valid_q && !sym_ready;
    if (load) begin
      cnt_d   = '0;
      sh_d    = '0;
      phase_d = phase_load;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sh_q    <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign phase_sel = phase_q;
  assign sym_valid = valid_q;

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Bench for psk_symbol_mapper: a QPSK instance (index 0) and an 8-PSK
// instance (index 1) driven by directed sequences, checked every cycle
// against a bit-list/lookup-table model plus literal expected phase codes.
module tb_psk_symbol_mapper;

  logic       clk = 1'b0;
  logic       rst;
  logic       bin  [2];
  logic       bval [2];
  logic       brdy [2];
  logic       fl   [2];
  logic       sr   [2];
  logic       sv   [2];
  logic [2:0] ph   [2];

  int vectors = 0;
  int errs    = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  psk_symbol_mapper #(.BITS_PER_SYM(2)) dut_qpsk (
    .clk(clk), .rst(rst), .bit_in(bin[0]), .bit_valid(bval[0]),
    .bit_ready(brdy[0]), .flush(fl[0]), .phase_sel(ph[0]),
    .sym_valid(sv[0]), .sym_ready(sr[0])
  );

  psk_symbol_mapper #(.BITS_PER_SYM(3)) dut_8psk (
    .clk(clk), .rst(rst), .bit_in(bin[1]), .bit_valid(bval[1]),
    .bit_ready(brdy[1]), .flush(fl[1]), .phase_sel(ph[1]),
    .sym_valid(sv[1]), .sym_ready(sr[1])
  );

  // Mapping tables indexed by the symbol value (MSB = first bit).
  int qmap [4] = '{1, 3, 7, 5};
  int pmap [8] = '{0, 1, 3, 2, 7, 6, 4, 5};

  // Model: bits collected so far as an integer, buffered output, pending flush.
  int m_n     [2];
  int m_v     [2];
  int m_phase [2];
  bit m_valid [2];
  bit m_pend  [2];

  function automatic bit m_ready(int k);
    return !m_pend[k] && (m_n[k] != k + 1 || !m_valid[k] || sr[k] === 1'b1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int nb, n, v, sym, code;
      bit space, acc, emit;
      if (rst === 1'b1) begin
        m_n[k] = 0; m_v[k] = 0; m_phase[k] = 0; m_valid[k] = 0; m_pend[k] = 0;
      end else begin
        nb    = k + 2;
        space = !m_valid[k] || sr[k] === 1'b1;
        acc   = bval[k] === 1'b1 && m_ready(k);
        n     = m_n[k];
        v     = m_v[k];
        if (acc) begin
          v = v * 2 + ((bin[k] === 1'b1) ? 1 : 0);
          n = n + 1;
        end
        emit = 0;
        sym  = 0;
        if (n == nb) begin
          emit = 1; sym = v; n = 0; v = 0;
        end else if ((fl[k] === 1'b1 || m_pend[k]) && n > 0) begin
          if (space) begin
            emit = 1; sym = v << (nb - n); n = 0; v = 0;
          end
          m_pend[k] = !space;
        end
        code = (nb == 2) ? qmap[sym] : pmap[sym];
        if (emit) begin
          m_valid[k] = 1;
          m_pend[k]  = 0;
`ifdef PSK_DIFF_ENC_EN
          m_phase[k] = (m_phase[k] + code) % 8;
`else
          m_phase[k] = code;
`endif
        end else if (m_valid[k] && sr[k] === 1'b1) begin
          m_valid[k] = 0;
        end
        m_n[k] = n;
        m_v[k] = v;
      end
    end
  end

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Literal phase expectation; the second value applies with differential encoding.
  task automatic chk_ph(string nm, int k, int plain, int diff);
`ifdef PSK_DIFF_ENC_EN
    chk(nm, k, 32'(ph[k]), 32'(diff));
`else
    chk(nm, k, 32'(ph[k]), 32'(plain));
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("model bit_ready", k, 32'(brdy[k]), 32'(m_ready(k)));
        chk("model sym_valid", k, 32'(sv[k]), 32'(m_valid[k]));
        chk("model phase_sel", k, 32'(ph[k]), 32'(m_phase[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      bval[k] = 0; fl[k] = 0; bin[k] = 0;
    end
    rst = 1;
    step();
    rst = 0;
  endtask

  logic t1 [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  int   e1p[4] = '{1, 3, 5, 7};
  int   e1d[4] = '{1, 4, 1, 0};
  logic t2 [6] = '{0, 1, 1, 1, 0, 0};
  logic t6 [6] = '{0, 0, 0, 0, 0, 1};
  int   e6 [3] = '{1, 2, 5};

  initial begin
    for (int k = 0; k < 2; k++) begin
      bin[k] = 0; bval[k] = 0; fl[k] = 0; sr[k] = 1;
    end
    rst = 1;
    step();
    step();
    rst = 0;
    chk_en = 1;
    for (int k = 0; k < 2; k++) begin
      chk("reset sym_valid", k, 32'(sv[k]), 0);
      chk("reset phase_sel", k, 32'(ph[k]), 0);
    end

    // 1: QPSK streaming, sym_ready high
    do_reset();
    sr[0] = 1;
    for (int i = 0; i < 8; i++) begin
      bval[0] = 1; bin[0] = t1[i];
      #1;
      chk("t1 bit_ready", 0, 32'(brdy[0]), 1);
      step();
      if (i % 2 == 1) begin
        chk_ph("t1 phase", 0, e1p[i / 2], e1d[i / 2]);
        chk("t1 valid pulse", 0, 32'(sv[0]), 1);
      end else begin
        chk("t1 valid idle", 0, 32'(sv[0]), 0);
      end
    end
    bval[0] = 0;

    // 2: 8-PSK, 011 then 100
    do_reset();
    sr[1] = 1;
    for (int i = 0; i < 6; i++) begin
      bval[1] = 1; bin[1] = t2[i];
      step();
      if (i == 2) chk_ph("t2 sym011", 1, 2, 2);
      if (i == 5) chk_ph("t2 sym100", 1, 7, 1);
    end
    bval[1] = 0;

    // 3: QPSK backpressure
    do_reset();
    sr[0] = 0;
    bval[0] = 1; bin[0] = 1; step();
    bin[0] = 1; step();
    chk_ph("t3 held sym", 0, 5, 5);
    bin[0] = 0; step();
    bin[0] = 1;
    #1;
    chk("t3 stall ready", 0, 32'(brdy[0]), 0);
    step();
    chk("t3 stall ready2", 0, 32'(brdy[0]), 0);
    chk("t3 held valid", 0, 32'(sv[0]), 1);
    chk_ph("t3 held phase", 0, 5, 5);
    sr[0] = 1;
    #1;
    chk("t3 release ready", 0, 32'(brdy[0]), 1);
    step();
    chk("t3 reload valid", 0, 32'(sv[0]), 1);
    chk_ph("t3 reload phase", 0, 3, 0);
    bval[0] = 0;
    step();
    chk("t3 drained", 0, 32'(sv[0]), 0);
    chk_ph("t3 phase hold", 0, 3, 0);

    // 4: 8-PSK flush cases
    do_reset();
    sr[1] = 1;
    bval[1] = 1; bin[1] = 1; step();
    bval[1] = 0; fl[1] = 1; step();
    chk("t4a flush valid", 1, 32'(sv[1]), 1);
    chk_ph("t4a pad 100", 1, 7, 7);
    step();
    chk("t4a empty flush", 1, 32'(sv[1]), 0);
    chk_ph("t4a phase hold", 1, 7, 7);
    fl[1] = 0;
    bval[1] = 1; bin[1] = 1; step();
    fl[1] = 1; step();
    chk_ph("t4b pad 110", 1, 4, 3);
    fl[1] = 0; bval[1] = 0; step();
    bval[1] = 1; bin[1] = 0; step();
    bin[1] = 1; step();
    bin[1] = 0; fl[1] = 1; step();
    chk_ph("t4c full+flush", 1, 3, 6);
    fl[1] = 0; bval[1] = 0; step();
    chk("t4c no extra", 1, 32'(sv[1]), 0);
    sr[1] = 0;
    bval[1] = 1; bin[1] = 1; step(); step(); step();
    chk_ph("t4d held 111", 1, 5, 3);
    step();
    bval[1] = 0; fl[1] = 1; step();
    fl[1] = 0; bval[1] = 1; bin[1] = 0;
    #1;
    chk("t4d pending ready", 1, 32'(brdy[1]), 0);
    step();
    chk("t4d pending ready2", 1, 32'(brdy[1]), 0);
    chk_ph("t4d still held", 1, 5, 3);
    sr[1] = 1;
    #1;
    chk("t4d drain ready", 1, 32'(brdy[1]), 0);
    step();
    bval[1] = 0;
    chk("t4d flushed valid", 1, 32'(sv[1]), 1);
    chk_ph("t4d pad 100", 1, 7, 2);
    step();
    chk("t4d drained", 1, 32'(sv[1]), 0);

    // 5: reset mid-operation
    do_reset();
    sr[0] = 0;
    bval[0] = 1; bin[0] = 1; step();
    bin[0] = 0; step();
    chk_ph("t5 full", 0, 7, 7);
    bin[0] = 1; step();
    bval[0] = 0; rst = 1; step();
    rst = 0;
    chk("t5 rst valid", 0, 32'(sv[0]), 0);
    chk_ph("t5 rst phase", 0, 0, 0);
    sr[0] = 1;
    bval[0] = 1; bin[0] = 0; step(); step();
    bval[0] = 0;
    chk("t5 post valid", 0, 32'(sv[0]), 1);
    chk_ph("t5 post 001", 0, 1, 1);

`ifdef PSK_DIFF_ENC_EN
    // 6: differential accumulation, QPSK 00,00,01
    do_reset();
    sr[0] = 1;
    for (int i = 0; i < 6; i++) begin
      bval[0] = 1; bin[0] = t6[i];
      step();
      if (i % 2 == 1) chk("t6 acc phase", 0, 32'(ph[0]), 32'(e6[i / 2]));
    end
    bval[0] = 0;
`endif

    step();
    step();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
